// File: rtl/pipe_stage.sv
// pipe_stage: inter-stage pipeline register with valid/ready handshake, flush,
// bubble insertion and an optional skid entry that registers the ready path.
module pipe_stage #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] KILL_MASK = '1,
  parameter int unsigned      SKID      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             bubble,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  logic             m_valid, m_valid_n;
  logic [WIDTH-1:0] m_data, m_data_n;
  logic             s_valid, s_valid_n;
  logic [WIDTH-1:0] s_data, s_data_n;
  logic             ready_c;
  logic             in_fire;
  logic             adv;

  // Masked fields take their reset value so an invalid entry has no side effects.
  function automatic logic [WIDTH-1:0] kill(input logic [WIDTH-1:0] x);
    return (x & ~KILL_MASK) | (RESET_VAL & KILL_MASK);
  endfunction

  // With a skid entry, ready depends only on held state and the stall input.
  always_comb begin
    if (SKID != 0) ready_c = !s_valid && !bubble;
    else           ready_c = (out_ready || !m_valid) && !bubble;
  end

  assign in_ready  = ready_c && !rst;
  assign in_fire   = in_valid && in_ready;
  assign adv       = (m_valid && out_ready) || !m_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign occ       = {1'b0, m_valid} + {1'b0, s_valid};

  always_comb begin
    m_valid_n = m_valid;
    m_data_n  = m_data;
    s_valid_n = s_valid;
    s_data_n  = s_data;
    if (flush) begin
      m_valid_n = 1'b0;
      m_data_n  = kill(m_data);
      s_valid_n = 1'b0;
    end else if (SKID != 0) begin
      if (adv) begin
        if (s_valid) begin
          m_valid_n = 1'b1;
          m_data_n  = s_data;
          s_valid_n = in_fire;
          if (in_fire) s_data_n = in_data;
        end else if (in_fire) begin
          m_valid_n = 1'b1;
          m_data_n  = in_data;
        end else begin
          m_valid_n = 1'b0;
          m_data_n  = kill(in_data);
        end
      end else if (in_fire) begin
        s_valid_n = 1'b1;
        s_data_n  = in_data;
      end
    end else if (adv) begin
      m_valid_n = in_fire;
      m_data_n  = in_fire ? in_data : kill(in_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= RESET_VAL;
      s_valid <= 1'b0;
      s_data  <= RESET_VAL;
    end else begin
      m_valid <= m_valid_n;
      m_data  <= m_data_n;
      s_valid <= s_valid_n;
      s_data  <= s_data_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: a skid instance and a single-entry instance share stimulus
// and are compared every cycle against a queue-level model, plus directed literals.
module tb_pipe_stage;

  localparam logic [7:0] RV0 = 8'h00;
  localparam logic [7:0] KM0 = 8'h03;
  localparam logic [7:0] RV1 = 8'hA5;
  localparam logic [7:0] KM1 = 8'hF0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid, bubble, flush, out_ready;
  logic [7:0] in_data;
  logic [1:0] ir, ov;
  logic [7:0] od [2];
  logic [1:0] oc [2];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(8), .RESET_VAL(RV0), .KILL_MASK(KM0), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .bubble(bubble), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .occ(oc[0]));

  pipe_stage #(.WIDTH(8), .RESET_VAL(RV1), .KILL_MASK(KM1), .SKID(0)) u_flow (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .bubble(bubble), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .occ(oc[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Model: an ordered list of held beats (capacity 2 or 1) plus the idle payload.
  int         mcnt  [2] = '{0, 0};
  logic [7:0] mdat  [2][2];
  logic [7:0] midle [2] = '{RV0, RV1};

  function automatic logic [7:0] kill_fn(input int i, input logic [7:0] x);
    if (i == 0) return (x & ~KM0) | (RV0 & KM0);
    return (x & ~KM1) | (RV1 & KM1);
  endfunction

  function automatic logic exp_ready(input int i);
    if (rst || bubble) return 1'b0;
    if (i == 0) return mcnt[0] < 2;
    return out_ready || (mcnt[1] == 0);
  endfunction

  always @(posedge clk or posedge rst) begin : p_model
    logic rdy, ofire, ifire;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mcnt[i]  = 0;
        midle[i] = (i == 0) ? RV0 : RV1;
      end else begin
        rdy   = exp_ready(i);
        ofire = (mcnt[i] > 0) && out_ready;
        ifire = in_valid && rdy;
        if (flush) begin
          midle[i] = kill_fn(i, (mcnt[i] > 0) ? mdat[i][0] : midle[i]);
          mcnt[i]  = 0;
        end else begin
          if (ofire) begin
            mdat[i][0] = mdat[i][1];
            mcnt[i]--;
          end
          if (ifire) begin
            mdat[i][mcnt[i]] = in_data;
            mcnt[i]++;
          end
          if (mcnt[i] == 0) midle[i] = kill_fn(i, in_data);
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_out_valid", i), 32'(ov[i]), 32'(mcnt[i] > 0));
      chk($sformatf("u%0d_out_data", i), 32'(od[i]),
          32'((mcnt[i] > 0) ? mdat[i][0] : midle[i]));
      chk($sformatf("u%0d_occ", i), 32'(oc[i]), 32'(mcnt[i]));
      chk($sformatf("u%0d_in_ready", i), 32'(ir[i]), 32'(exp_ready(i)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    in_valid = 1'b0; in_data = 8'h00; bubble = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_out_data0", 32'(od[0]), 32'h00);
    chk("rst_out_data1", 32'(od[1]), 32'hA5);
    chk("rst_occ", 32'(oc[0]), 32'd0);
    chk("rst_in_ready", 32'(ir[0]), 32'd0);
    step();
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(ir[0]), 32'd1);

    // Streaming 1,2,3,4 under continuous out_ready
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("stream_data_%0d", k), 32'(od[0]), 32'(k));
      chk($sformatf("stream_occ_%0d", k), 32'(oc[0]), 32'd1);
      in_data = 8'(k + 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 32'(ov[0]), 32'd0);

    // Backpressure A,B,C
    in_valid = 1'b1; in_data = 8'hA1; out_ready = 1'b0;
    step();
    chk("bp_a_out", 32'(od[0]), 32'hA1);
    in_data = 8'hB2;
    step();
    chk("bp_occ2", 32'(oc[0]), 32'd2);
    chk("bp_ready0", 32'(ir[0]), 32'd0);
    chk("bp_hold_a", 32'(od[0]), 32'hA1);
    chk("model_skid_cnt", 32'(mcnt[0]), 32'd2);
    chk("model_skid_b", 32'(mdat[0][1]), 32'hB2);
    in_data = 8'hC3;
    step();
    chk("bp_hold_a2", 32'(od[0]), 32'hA1);
    step();
    chk("bp_hold_a3", 32'(od[0]), 32'hA1);
    chk("bp_ready0_3", 32'(ir[0]), 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", 32'(od[0]), 32'hB2);
    chk("bp_occ1", 32'(oc[0]), 32'd1);
    chk("bp_ready1", 32'(ir[0]), 32'd1);
    step();
    chk("bp_out_c", 32'(od[0]), 32'hC3);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(ov[0]), 32'd0);

    // Bubble with M advancing
    bubble = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    #1 chk("bub_ready0", 32'(ir[0]), 32'd0);
    step();
    chk("bub_out_valid", 32'(ov[0]), 32'd0);
    chk("bub_out_data", 32'(od[0]), 32'hFC);
    chk("bub_out_data1", 32'(od[1]), 32'hAF);
    bubble = 1'b0;
    step();
    chk("bub_accept_v", 32'(ov[0]), 32'd1);
    chk("bub_accept_d", 32'(od[0]), 32'hFF);

    // Flush with M and S full, then flush with a same-cycle accept
    out_ready = 1'b0; in_data = 8'h11;
    step();
    chk("fl_full", 32'(oc[0]), 32'd2);
    flush = 1'b1; in_data = 8'h22;
    step();
    chk("fl_valid", 32'(ov[0]), 32'd0);
    chk("fl_occ", 32'(oc[0]), 32'd0);
    chk("fl_mask", 32'(od[0] & KM0), 32'(RV0 & KM0));
    flush = 1'b0; in_data = 8'h33;
    step();
    chk("fl_reload", 32'(od[0]), 32'h33);
    flush = 1'b1; in_data = 8'h77;
    #1 chk("fl_in_ready", 32'(ir[0]), 32'd1);
    step();
    chk("fl2_valid", 32'(ov[0]), 32'd0);
    chk("fl2_data", 32'(od[0]), 32'h30);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl2_no_beat", 32'(ov[0]), 32'd0);
    chk("fl2_idle", 32'(od[0]), 32'h74);

    // Reset mid-stream with two held beats
    in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b0;
    step();
    in_data = 8'h0B;
    step();
    chk("mid_occ2", 32'(oc[0]), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_occ", 32'(oc[0]), 32'd0);
    chk("mid_rst_data0", 32'(od[0]), 32'(RV0));
    chk("mid_rst_data1", 32'(od[1]), 32'(RV1));
    chk("mid_rst_ready", 32'(ir[0]), 32'd0);
    step();
    chk("mid_rst_ready2", 32'(ir[0]), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("mid_rel_ready", 32'(ir[0]), 32'd1);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      out_ready = ($urandom % 5) < 3;
      bubble    = ($urandom % 10) == 0;
      flush     = ($urandom % 20) == 0;
    end
    in_valid = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
